// File: rtl/downsample_stream.sv
// Raster-order stream decimator: forwards pixels on a STRIDE_X x STRIDE_Y grid
// (offset OFF_X/OFF_Y) through a single registered output stage.
module downsample_stream #(
  parameter int WIDTH    = 16,
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int STRIDE_X = 2,
  parameter int STRIDE_Y = 2,
  parameter int OFF_X    = 0,
  parameter int OFF_Y    = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] data_in_data,
  input  logic             data_in_valid,
  output logic             data_in_ready,
  output logic [WIDTH-1:0] data_out_data,
  output logic             data_out_valid,
  input  logic             data_out_ready,
  output logic             data_out_last,
  output logic             frame_done
);

  localparam int XW  = (IMG_W    > 1) ? $clog2(IMG_W)    : 1;
  localparam int YW  = (IMG_H    > 1) ? $clog2(IMG_H)    : 1;
  localparam int PXW = (STRIDE_X > 1) ? $clog2(STRIDE_X) : 1;
  localparam int PYW = (STRIDE_Y > 1) ? $clog2(STRIDE_Y) : 1;

  localparam logic [XW-1:0]  X_MAX   = XW'(IMG_W - 1);
  localparam logic [YW-1:0]  Y_MAX   = YW'(IMG_H - 1);
  localparam logic [PXW-1:0] PX_MAX  = PXW'(STRIDE_X - 1);
  localparam logic [PYW-1:0] PY_MAX  = PYW'(STRIDE_Y - 1);
  localparam logic [PXW-1:0] PX_KEEP = PXW'(OFF_X);
  localparam logic [PYW-1:0] PY_KEEP = PYW'(OFF_Y);

  // Coordinates of the final kept pixel of a frame, fixed at elaboration.
  localparam logic [XW-1:0] LAST_X = XW'(IMG_W - 1 - ((IMG_W - 1 - OFF_X) % STRIDE_X));
  localparam logic [YW-1:0] LAST_Y = YW'(IMG_H - 1 - ((IMG_H - 1 - OFF_Y) % STRIDE_Y));

  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [PXW-1:0] px;
  logic [PYW-1:0] py;
  logic           full;
  logic           keep_cur;
  logic           acc;
  logic           pop;
  logic           x_end;
  logic           y_end;

  assign keep_cur       = (px == PX_KEEP) & (py == PY_KEEP);
  assign data_in_ready  = ~keep_cur | ~full | data_out_ready;
  assign acc            = data_in_valid & data_in_ready;
  assign pop            = full & data_out_ready;
  assign x_end          = (x == X_MAX);
  assign y_end          = (y == Y_MAX);
  assign data_out_valid = full;

  // Phase counters wrap alongside x/y so no modulo hardware is needed.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      x  <= '0;
      y  <= '0;
      px <= '0;
      py <= '0;
    end else if (acc) begin
      if (x_end) begin
        x  <= '0;
        px <= '0;
        if (y_end) begin
          y  <= '0;
          py <= '0;
        end else begin
          y  <= y + 1'b1;
          py <= (py == PY_MAX) ? '0 : py + 1'b1;
        end
      end else begin
        x  <= x + 1'b1;
        px <= (px == PX_MAX) ? '0 : px + 1'b1;
      end
    end
  end

  // A load takes priority over a pop so back-to-back kept pixels flow without a bubble.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      full          <= 1'b0;
      data_out_data <= '0;
      data_out_last <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= acc & x_end & y_end;
      if (acc & keep_cur) begin
        full          <= 1'b1;
        data_out_data <= data_in_data;
        data_out_last <= (x == LAST_X) & (y == LAST_Y);
      end else if (pop) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_downsample_stream.sv
// Scoreboard bench for downsample_stream: four parameterisations, one exercised at a time,
// expected outputs derived from pixel coordinates when each input is accepted.
module tb_downsample_stream;

  localparam int N = 4;
  localparam int PW [N]  = '{4, 4, 4, 32};
  localparam int PH [N]  = '{4, 4, 4, 32};
  localparam int PSX [N] = '{2, 2, 1, 2};
  localparam int PSY [N] = '{2, 2, 1, 2};
  localparam int POX [N] = '{0, 1, 0, 0};
  localparam int POY [N] = '{0, 1, 0, 0};

  typedef struct packed {
    logic [15:0] d;
    logic        l;
    logic [31:0] c;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] in_data;
  logic        in_valid   [N];
  logic        in_ready   [N];
  logic [15:0] out_data   [N];
  logic        out_valid  [N];
  logic        out_ready  [N];
  logic        out_last   [N];
  logic        frame_done [N];

  exp_t exp_q[$];
  int   fd_exp_q[$];
  int   fd_got_q[$];
  int   checks = 0;
  int   errors = 0;
  int   sel = 0;
  int   idx = 0;
  int   stalls = 0;
  int   cyc = 0;
  int   fd_gap = -1;
  bit   check_lat = 1'b1;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  downsample_stream #(.WIDTH(16), .IMG_W(4), .IMG_H(4), .STRIDE_X(2), .STRIDE_Y(2), .OFF_X(0), .OFF_Y(0)) u0 (
    .CLK(CLK), .RESET(RESET), .data_in_data(in_data), .data_in_valid(in_valid[0]), .data_in_ready(in_ready[0]),
    .data_out_data(out_data[0]), .data_out_valid(out_valid[0]), .data_out_ready(out_ready[0]),
    .data_out_last(out_last[0]), .frame_done(frame_done[0]));

  downsample_stream #(.WIDTH(16), .IMG_W(4), .IMG_H(4), .STRIDE_X(2), .STRIDE_Y(2), .OFF_X(1), .OFF_Y(1)) u1 (
    .CLK(CLK), .RESET(RESET), .data_in_data(in_data), .data_in_valid(in_valid[1]), .data_in_ready(in_ready[1]),
    .data_out_data(out_data[1]), .data_out_valid(out_valid[1]), .data_out_ready(out_ready[1]),
    .data_out_last(out_last[1]), .frame_done(frame_done[1]));

  downsample_stream #(.WIDTH(16), .IMG_W(4), .IMG_H(4), .STRIDE_X(1), .STRIDE_Y(1), .OFF_X(0), .OFF_Y(0)) u2 (
    .CLK(CLK), .RESET(RESET), .data_in_data(in_data), .data_in_valid(in_valid[2]), .data_in_ready(in_ready[2]),
    .data_out_data(out_data[2]), .data_out_valid(out_valid[2]), .data_out_ready(out_ready[2]),
    .data_out_last(out_last[2]), .frame_done(frame_done[2]));

  downsample_stream u3 (
    .CLK(CLK), .RESET(RESET), .data_in_data(in_data), .data_in_valid(in_valid[3]), .data_in_ready(in_ready[3]),
    .data_out_data(out_data[3]), .data_out_valid(out_valid[3]), .data_out_ready(out_ready[3]),
    .data_out_last(out_last[3]), .frame_done(frame_done[3]));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic bit isKept(input int s, input int x, input int y);
    return ((x % PSX[s]) == POX[s]) && ((y % PSY[s]) == POY[s]);
  endfunction

  // Last kept pixel: kept, and no later kept column in its row nor later kept row.
  function automatic bit isLast(input int s, input int x, input int y);
    if (!isKept(s, x, y)) return 1'b0;
    for (int xx = x + 1; xx < PW[s]; xx++) if ((xx % PSX[s]) == POX[s]) return 1'b0;
    for (int yy = y + 1; yy < PH[s]; yy++) if ((yy % PSY[s]) == POY[s]) return 1'b0;
    return 1'b1;
  endfunction

  // Present one pixel on the selected instance and hold it until accepted.
  task automatic applyStimulus(input logic [15:0] d);
    int  budget = 0;
    bit  done = 1'b0;
    int  x, y;
    exp_t e;
    in_data = d;
    in_valid[sel] = 1'b1;
    while (!done) begin
      @(negedge CLK);
      if (in_ready[sel]) begin
        x = idx % PW[sel];
        y = idx / PW[sel];
        if (isKept(sel, x, y)) begin
          e.d = d;
          e.l = isLast(sel, x, y);
          e.c = cyc;
          exp_q.push_back(e);
        end
        if (idx == PW[sel] * PH[sel] - 1) fd_exp_q.push_back(cyc + 1);
        idx = (idx + 1) % (PW[sel] * PH[sel]);
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge CLK);
      #1;
      budget++;
      if (!done && budget > 50) begin
        checkOutput("accept_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
    end
    in_valid[sel] = 1'b0;
  endtask

  task automatic endTest(input string tag);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge CLK);
    repeat (3) @(posedge CLK);
    #1;
    checkOutput({tag, "_drain"}, exp_q.size(), 0);
    checkOutput({tag, "_fd_count"}, fd_got_q.size(), fd_exp_q.size());
    for (int i = 0; i < fd_got_q.size() && i < fd_exp_q.size(); i++)
      checkOutput({tag, "_fd_cycle"}, fd_got_q[i], fd_exp_q[i]);
    fd_gap = (fd_got_q.size() >= 2) ? fd_got_q[1] - fd_got_q[0] : -1;
    exp_q.delete();
    fd_exp_q.delete();
    fd_got_q.delete();
  endtask

  // Output monitor: pops the scoreboard on every output handshake.
  always @(negedge CLK) begin
    exp_t e;
    if (!RESET) begin
      if (frame_done[sel]) fd_got_q.push_back(cyc);
      if (out_valid[sel] && out_ready[sel]) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out", {16'd0, out_data[sel]}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_data", {16'd0, out_data[sel]}, {16'd0, e.d});
          checkOutput("out_last", {31'd0, out_last[sel]}, {31'd0, e.l});
          if (check_lat) checkOutput("latency", cyc, e.c + 1);
        end
      end
    end
  end

  initial begin
    RESET   = 1'b1;
    in_data = '0;
    for (int i = 0; i < N; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
    end
    repeat (2) @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("rst_valid%0d", i), {31'd0, out_valid[i]}, 32'd0);
      checkOutput($sformatf("rst_data%0d", i), {16'd0, out_data[i]}, 32'd0);
      checkOutput($sformatf("rst_last%0d", i), {31'd0, out_last[i]}, 32'd0);
      checkOutput($sformatf("rst_fd%0d", i), {31'd0, frame_done[i]}, 32'd0);
      checkOutput($sformatf("rst_in_ready%0d", i), {31'd0, in_ready[i]}, 32'd1);
    end
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    // Decimation plus back-to-back frames, stride 2, offset 0
    sel = 0; idx = 0; stalls = 0;
    for (int k = 0; k < 16; k++) applyStimulus(16'(k));
    for (int k = 0; k < 16; k++) applyStimulus(16'(100 + k));
    endTest("dec");
    checkOutput("dec_stalls", stalls, 0);
    checkOutput("dec_fd_gap", fd_gap, 16);

    // Phase offset 1/1
    sel = 1; idx = 0; stalls = 0;
    for (int k = 0; k < 16; k++) applyStimulus(16'(k));
    endTest("phase");
    checkOutput("phase_stalls", stalls, 0);

    // Stride 1: plain pipeline register at full throughput
    sel = 2; idx = 0; stalls = 0;
    for (int k = 0; k < 16; k++) applyStimulus(16'(k));
    endTest("pipe");
    checkOutput("pipe_stalls", stalls, 0);

    // Backpressure on the default 32x32 instance
    sel = 3; idx = 0; check_lat = 1'b0;
    out_ready[3] = 1'b0;
    applyStimulus(16'd0);
    applyStimulus(16'd1);
    in_data = 16'd2;
    in_valid[3] = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      checkOutput("bp_in_ready", {31'd0, in_ready[3]}, 32'd0);
      checkOutput("bp_hold_valid", {31'd0, out_valid[3]}, 32'd1);
      checkOutput("bp_hold_data", {16'd0, out_data[3]}, 32'd0);
    end
    @(posedge CLK);
    #1;
    out_ready[3] = 1'b1;
    for (int k = 2; k < 6; k++) applyStimulus(16'(k));
    endTest("bp");
    check_lat = 1'b1;

    // Asynchronous reset with the output register full mid-frame
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    idx = 0;
    for (int k = 0; k < 4; k++) applyStimulus(16'(50 + k));
    out_ready[3] = 1'b0;
    applyStimulus(16'd54);
    checkOutput("mid_full_valid", {31'd0, out_valid[3]}, 32'd1);
    RESET = 1'b1;
    #1;
    checkOutput("mid_rst_valid", {31'd0, out_valid[3]}, 32'd0);
    checkOutput("mid_rst_data", {16'd0, out_data[3]}, 32'd0);
    checkOutput("mid_rst_last", {31'd0, out_last[3]}, 32'd0);
    exp_q.delete();
    fd_exp_q.delete();
    fd_got_q.delete();
    idx = 0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    out_ready[3] = 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus(16'(200 + k));
    endTest("mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/downsample_stream.md
Name: downsample_stream

Overview:
- Parametrised successor to the fixed 32x32, 2:1, 16-bit downsample channel.
- Consumes a raster-order pixel stream over a valid/ready handshake.
- Forwards only pixels whose column and row fall on a configurable stride grid with a phase offset, so the output is an IMG_W/STRIDE_X by IMG_H/STRIDE_Y subimage.
- Adds a registered output stage, a last-pixel marker, a frame-done pulse and asynchronous reset.
- Sits between a line-buffered image source and downstream stencil/accumulator stages.

Parameters:
- WIDTH, 16, pixel data width in bits.
- IMG_W, 32, pixels per row (>=1).
- IMG_H, 32, rows per frame (>=1).
- STRIDE_X, 2, column decimation factor (>=1, <=IMG_W).
- STRIDE_Y, 2, row decimation factor (>=1, <=IMG_H).
- OFF_X, 0, kept column phase, 0..STRIDE_X-1.
- OFF_Y, 0, kept row phase, 0..STRIDE_Y-1.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- data_in_data  input  WIDTH  input pixel.
- data_in_valid  input  1  input pixel present.
- data_in_ready  output  1  block accepts input this cycle.
- data_out_data  output  WIDTH  kept pixel, registered.
- data_out_valid  output  1  output register holds a kept pixel.
- data_out_ready  input  1  downstream accepts output this cycle.
- data_out_last  output  1  qualifies data_out_data as the final kept pixel of the frame.
- frame_done  output  1  one-cycle pulse after the last input pixel of a frame is accepted.

Behaviour:
- Counters:
  - x: 0..IMG_W-1, width clog2(IMG_W) with minimum 1.
  - y: 0..IMG_H-1.
  - Phase counters px: 0..STRIDE_X-1 and py: 0..STRIDE_Y-1. No modulo operators.
- keep_cur = (px==OFF_X) & (py==OFF_Y), computed combinationally from the current counters.
- Accept: acc = data_in_valid & data_in_ready. Counters advance only on acc.
- Advance rules:
  - If x==IMG_W-1: x=0, px=0, then advance the row.
  - Otherwise: x+1, and px+1 wrapping to 0 at STRIDE_X-1.
  - Row advance: if y==IMG_H-1, y=0 and py=0; otherwise y+1, and py wraps at STRIDE_Y-1.
- Output register: full flag, data, last.
  - pop = data_out_valid & data_out_ready.
  - data_in_ready = ~keep_cur | ~full | data_out_ready (combinational, no dependency on data_in_valid).
  - Dropped pixels are always accepted, even while the output register is full.
- Register update on acc & keep_cur: load data_in_data; full=1; last=1 iff x==IMG_W-1-((IMG_W-1-OFF_X)%STRIDE_X) and y==IMG_H-1-((IMG_H-1-OFF_Y)%STRIDE_Y). Both values are elaboration-time constants.
- Simultaneous pop and load: the register holds the new pixel, full stays 1 (full throughput, no bubble).
- Pop without load: full=0. Data holds its value, don't-care while not valid.
- Latency: a kept pixel accepted in cycle N is visible on data_out_* in cycle N+1.
- data_out_valid = full. data_out_last is only meaningful while full.
- data_out_data, data_out_last and data_out_valid are stable while valid & ~ready.
- frame_done: registered, high for exactly one cycle following acc of pixel (IMG_W-1, IMG_H-1). It is independent of output drain.
- Reset values: x=y=px=py=0; full=0; data_out_valid=0; data_out_data=0; data_out_last=0; frame_done=0. data_in_ready after reset equals 1.
- Reset asserted mid-frame: counters return to 0 and any buffered pixel is discarded. The next accepted pixel is treated as (0,0).
- Degenerate case STRIDE_X=STRIDE_Y=1: every pixel is kept; the block behaves as a 1-deep pipeline register.
- Wrap-around: frames are back-to-back with no idle cycle required. Pixel (0,0) of the next frame may be accepted in the cycle after the last pixel of the current frame.

Test Plan:
- Decimation: IMG_W=IMG_H=4, STRIDE 2/2, OFF 0/0, in_data=0..15 with valid and out_ready always high -> outputs exactly 0,2,8,10 with last=1 on 10; frame_done pulses one cycle after input 15 is accepted; in_ready stays 1 throughout.
- Phase offset: same configuration, OFF_X=1, OFF_Y=1 -> outputs 5,7,13,15 with last on 15.
- Backpressure: default 32x32, out_ready=0 after the first kept pixel -> output holds pixel 0 stable; pixel 1 (dropped) is accepted; in_ready=0 while pixel 2 is presented; releasing ready yields 0 then 2 with no loss or duplication.
- Full throughput: STRIDE 1/1, 4x4, valid and ready high -> one output per cycle, outputs 0..15 at 1-cycle latency, last on 15.
- Reset mid-frame: assert RESET after 5 accepted pixels while the output register is full -> valid=0 and data=0 immediately (asynchronous); the next frame restarts at (0,0) and the first kept pixel is the first post-reset input.
- Back-to-back frames: two 4x4 frames (values 0..15, then 100..115), stride 2 -> outputs 0,2,8,10,100,102,108,110; two frame_done pulses 16 cycles apart.
